// File: rtl/ap_si_wall_mult_pipe.sv
// Pipelined signed Baugh-Wooley multiplier with a per-transaction exact/approximate mode.
// In approximate mode the low APX_COLS product columns are OR-compressed and never carry out.
module ap_si_wall_mult_pipe #(
  parameter int DW       = 8,
  parameter int APX_COLS = 6,
  parameter int PIPE     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic signed [DW-1:0]   muld,
  input  logic signed [DW-1:0]   mulr,
  input  logic                   mode,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic signed [2*DW-1:0] res,
  output logic                   out_mode
);

  localparam int PW = 2 * DW;

  logic            en;
  logic            take;
  logic [PIPE-1:0] vld_pn;
  logic [PIPE-1:0] mode_pn;
  logic [DW-1:0]   pp;
  logic [PW-1:0]   row [DW+1];
  logic [PW-1:0]   hi_mask;
  logic [PW-1:0]   lo_or;
  logic [PW-1:0]   cs_s;
  logic [PW-1:0]   cs_c;
  logic [PW-1:0]   cs_t;
  logic [PW-1:0]   s_in;
  logic [PW-1:0]   c_in;

  assign en       = !out_vld || out_rdy;
  assign in_rdy   = en;
  assign take     = in_vld && en;
  assign out_vld  = vld_pn[PIPE-1];
  assign out_mode = mode_pn[PIPE-1];

  // Stage 0 input: partial-product rows, low-column OR, 3:2 carry-save reduction
  always_comb begin
    hi_mask = mode ? ({PW{1'b1}} << APX_COLS) : {PW{1'b1}};
    lo_or   = '0;
    pp      = '0;
    for (int j = 0; j < DW; j++) begin
      pp     = muld & {DW{mulr[j]}};
      pp     = pp ^ ((j == DW-1) ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}});
      row[j] = PW'(pp) << j;
      lo_or  = lo_or | (row[j] & ~hi_mask);
      row[j] = row[j] & hi_mask;
    end
    row[DW] = hi_mask & ((PW'(1) << DW) | (PW'(1) << (PW-1)));
    cs_s = row[0];
    cs_c = row[1];
    cs_t = '0;
    for (int k = 2; k <= DW; k++) begin
      cs_t = cs_s ^ cs_c ^ row[k];
      cs_c = ((cs_s & cs_c) | (cs_s & row[k]) | (cs_c & row[k])) << 1;
      cs_s = cs_t;
    end
  end

  // Masked rows keep every sum/carry bit above the OR region, so OR-merging is lossless
  assign s_in = cs_s | lo_or;
  assign c_in = cs_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pn  <= '0;
      mode_pn <= '0;
    end else if (en) begin
      vld_pn[0]  <= take;
      mode_pn[0] <= mode;
      for (int k = 1; k < PIPE; k++) begin
        vld_pn[k]  <= vld_pn[k-1];
        mode_pn[k] <= mode_pn[k-1];
      end
    end
  end

  generate
    if (PIPE == 1) begin : g_p1
      logic [PW-1:0] dat_p0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dat_p0 <= '0;
        else if (en) dat_p0 <= s_in + c_in;
      end

      assign res = dat_p0;
    end else begin : g_pn
      logic [PW-1:0] s_p0;
      logic [PW-1:0] c_p0;
      logic [PW-1:0] dat_pn [1:PIPE-1];

      always_ff @(posedge clk) begin
        if (en) begin
          s_p0 <= s_in;
          c_p0 <= c_in;
        end
      end

      // Stage 1: final carry-propagate adder; later stages only retime
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 1; k < PIPE; k++) dat_pn[k] <= '0;
        end else if (en) begin
          dat_pn[1] <= s_p0 + c_p0;
          for (int k = 2; k < PIPE; k++) dat_pn[k] <= dat_pn[k-1];
        end
      end

      assign res = dat_pn[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_ap_si_wall_mult_pipe.sv
// Bench for ap_si_wall_mult_pipe: hand-computed vectors, reset and stall sequences, streamed sweeps
// against a column-level reference on DW=8/APX_COLS=6/PIPE=2 and DW=12/APX_COLS=0/PIPE=3.
module tb_ap_si_wall_mult_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_vld, in_rdy, mode, out_vld, out_rdy, out_mode;
  logic signed [7:0]  muld, mulr;
  logic signed [15:0] res;
  logic               in_vld12, in_rdy12, mode12, out_vld12, out_mode12;
  logic signed [11:0] muld12, mulr12;
  logic signed [23:0] res12;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        m;
  } exp_t;

  vec_t vt [10];

  always #5 clk = ~clk;

  ap_si_wall_mult_pipe #(.DW(8), .APX_COLS(6), .PIPE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .muld(muld), .mulr(mulr), .mode(mode),
    .out_vld(out_vld), .out_rdy(out_rdy), .res(res), .out_mode(out_mode)
  );

  ap_si_wall_mult_pipe #(.DW(12), .APX_COLS(0), .PIPE(3)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld12), .in_rdy(in_rdy12),
    .muld(muld12), .mulr(mulr12), .mode(mode12),
    .out_vld(out_vld12), .out_rdy(out_rdy), .res(res12), .out_mode(out_mode12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Low columns: OR of Baugh-Wooley bits; high region: true product minus the exact low-column sum
  function automatic logic [31:0] ref_mult(input int a, input int b, input bit m,
                                           input int dw, input int apx);
    int          ac, j, bt;
    logic [31:0] pmask, lowsum, orb, full;
    ac     = m ? apx : 0;
    pmask  = (32'h1 << (2 * dw)) - 32'h1;
    full   = a * b;
    lowsum = '0;
    orb    = '0;
    for (int c = 0; c < ac; c++) begin
      for (int i = 0; i < dw; i++) begin
        j = c - i;
        if (j >= 0 && j < dw) begin
          bt = (((a >>> i) & 1) & ((b >>> j) & 1)) ^ (((i == dw-1) != (j == dw-1)) ? 1 : 0);
          lowsum = lowsum + (bt << c);
          orb    = orb | (bt << c);
        end
      end
    end
    return ((full - lowsum) & pmask & ~((32'h1 << ac) - 32'h1)) | orb;
  endfunction

  task automatic apply_vec(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    chk({name, "_in_rdy"}, in_rdy, 1);
    muld = v.a; mulr = v.b; mode = v.m; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_res"}, res[15:0], v.r);
    chk({name, "_out_mode"}, out_mode, v.m);
  endtask

  task automatic stream(input bit big, input int n, input bit sweep, input int stall_at);
    exp_t        q[$];
    exp_t        e;
    int          sent, got, cyc, ai, bi;
    bit          m, ov, ir;
    logic [11:0] ra, rb;
    logic [31:0] rr;
    logic [7:0]  btab [16];
    btab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h7F, 8'h80, 8'h81,
             8'hFF, 8'hFE, 8'h55, 8'hAA, 8'h40, 8'hC0, 8'h3C, 8'h99};
    sent = 0; got = 0; cyc = 0;
    while ((sent < n || q.size() != 0) && cyc < 2 * n + 100) begin
      @(negedge clk);
      cyc++;
      out_rdy = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      #1;
      ov = big ? out_vld12 : out_vld;
      ir = big ? in_rdy12 : in_rdy;
      rr = big ? {8'h00, res12[23:0]} : {16'h0000, res[15:0]};
      if (ov) begin
        chk("stream_result_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk($sformatf("stream%0d_res_%0d", big ? 12 : 8, got), rr, q[0].r);
          chk($sformatf("stream%0d_mode_%0d", big ? 12 : 8, got), big ? out_mode12 : out_mode, q[0].m);
          if (out_rdy) begin
            void'(q.pop_front());
            got++;
          end else begin
            chk("stall_in_rdy", ir, 0);
          end
        end
      end
      if (ir) begin
        if (sent < n) begin
          if (sweep) begin
            ra = 12'(sent & 255);
            rb = {4'h0, btab[(sent >> 8) & 15]};
            m  = sent[12];
          end else begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(0, 4095));
            m  = sent[0];
          end
          if (big) begin
            ai = int'($signed(ra));
            bi = int'($signed(rb));
            e.r = 32'(ai * bi) & 32'h00FF_FFFF;
            muld12 = ra; mulr12 = rb; mode12 = m; in_vld12 = 1'b1;
          end else begin
            ai = int'($signed(ra[7:0]));
            bi = int'($signed(rb[7:0]));
            e.r = ref_mult(ai, bi, m, 8, 6);
            muld = ra[7:0]; mulr = rb[7:0]; mode = m; in_vld = 1'b1;
          end
          e.m = m;
          q.push_back(e);
          sent++;
        end else begin
          in_vld = 1'b0;
          in_vld12 = 1'b0;
        end
      end
    end
    in_vld = 1'b0; in_vld12 = 1'b0; out_rdy = 1'b1;
    chk($sformatf("stream%0d_count", big ? 12 : 8), got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; muld = '0; mulr = '0; mode = 1'b0;
    in_vld12 = 1'b0; muld12 = '0; mulr12 = '0; mode12 = 1'b0;

    vt[0] = '{8'h03, 8'h03, 1'b0, 16'h0009};
    vt[1] = '{8'h03, 8'h03, 1'b1, 16'h0007};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 16'hFEFF};
    vt[3] = '{8'hFF, 8'hFF, 1'b0, 16'h0001};
    vt[4] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vt[5] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vt[6] = '{8'h7F, 8'h80, 1'b0, 16'hC080};
    vt[7] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vt[8] = '{8'h05, 8'h07, 1'b0, 16'h0023};
    vt[9] = '{8'h05, 8'h07, 1'b1, 16'h001F};

    @(negedge clk);
    chk("reset_out_vld", out_vld, 0);
    chk("reset_res", res[15:0], 0);
    chk("reset_out_mode", out_mode, 0);
    chk("reset_in_rdy", in_rdy, 1);
    chk("reset_out_vld12", out_vld12, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) apply_vec(vt[k], $sformatf("vec%0d", k));

    // Two transactions in flight, then asynchronous reset mid-cycle
    @(negedge clk);
    muld = 8'd3; mulr = 8'd3; mode = 1'b0; in_vld = 1'b1;
    @(negedge clk);
    muld = 8'd5; mulr = 8'd7; mode = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    chk("pre_reset_out_vld", out_vld, 1);
    chk("pre_reset_res", res[15:0], 16'h0009);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_vld", out_vld, 0);
    chk("async_reset_res", res[15:0], 0);
    chk("async_reset_out_mode", out_mode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_idle", out_vld, 0);
    end
    apply_vec(vt[9], "post_reset_vec");

    stream(1'b0, 50, 1'b0, 20);
    stream(1'b0, 8192, 1'b1, -1);
    stream(1'b1, 1000, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
